// File: rtl/ff_bank_if.sv
// Bus bundle for ff_bank: operand/control inputs and registered flip-flop outputs.
// illegal_cnt is present only when FF_BANK_ILLEGAL_CNT_EN is defined.
interface ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_sticky;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             illegal;
    logic             illegal_sticky;
`ifdef FF_BANK_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output en, mode, a, b, clr_sticky,
        input  q, q_bar, illegal, illegal_sticky, illegal_cnt
    );
    modport slave (
        input  en, mode, a, b, clr_sticky,
        output q, q_bar, illegal, illegal_sticky, illegal_cnt
    );
`else
    modport master (
        output en, mode, a, b, clr_sticky,
        input  q, q_bar, illegal, illegal_sticky
    );
    modport slave (
        input  en, mode, a, b, clr_sticky,
        output q, q_bar, illegal, illegal_sticky
    );
`endif
endinterface

// File: rtl/ff_bank.sv
// Multi-channel D/T/SR/JK flip-flop bank with independently registered q/q_bar and
// forbidden-SR flagging. Define FF_BANK_ILLEGAL_CNT_EN for the saturating event counter.
module ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    ff_bank_if.slave  bus
);
    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_bar_r;
    logic             illegal_r;
    logic             sticky_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] q_bar_nxt_s;
    logic [WIDTH-1:0] hold_s;
    logic             hit_s;

    // Per-channel next state; q and q_bar are computed separately so 0/0 survives.
    always_comb begin
        q_nxt_s     = q_r;
        q_bar_nxt_s = q_bar_r;
        hold_s      = ~bus.a & ~bus.b;
        if (bus.en) begin
            case (bus.mode)
                MODE_D: begin
                    q_nxt_s     = bus.a;
                    q_bar_nxt_s = ~bus.a;
                end
                MODE_T: begin
                    q_nxt_s     = (q_r & ~bus.a) | (~q_r & bus.a);
                    q_bar_nxt_s = (q_bar_r & ~bus.a) | (q_r & bus.a);
                end
                MODE_SR: begin
                    q_nxt_s     = (q_r & hold_s) | (bus.a & ~bus.b);
                    q_bar_nxt_s = (q_bar_r & hold_s) | (~bus.a & bus.b);
                end
                MODE_JK: begin
                    q_nxt_s     = (q_r & hold_s) | (bus.a & ~bus.b) | (bus.a & bus.b & ~q_r);
                    q_bar_nxt_s = (q_bar_r & hold_s) | (~bus.a & bus.b) | (bus.a & bus.b & q_r);
                end
                default: begin
                    q_nxt_s     = q_r;
                    q_bar_nxt_s = q_bar_r;
                end
            endcase
        end else begin
            q_nxt_s     = q_r;
            q_bar_nxt_s = q_bar_r;
        end
    end

    // One hit per edge regardless of how many channels see S=R=1.
    assign hit_s = bus.en & (bus.mode == MODE_SR) & (|(bus.a & bus.b));

    // Channel storage and illegal flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= {WIDTH{1'b0}};
            q_bar_r   <= {WIDTH{1'b1}};
            illegal_r <= 1'b0;
            sticky_r  <= 1'b0;
        end else begin
            q_r       <= q_nxt_s;
            q_bar_r   <= q_bar_nxt_s;
            illegal_r <= hit_s;
            sticky_r  <= hit_s | (sticky_r & ~bus.clr_sticky);
        end
    end

    assign bus.q              = q_r;
    assign bus.q_bar          = q_bar_r;
    assign bus.illegal        = illegal_r;
    assign bus.illegal_sticky = sticky_r;

`ifdef FF_BANK_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Saturating counter; a clear on a hit edge loads 1 so set wins over clear.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (bus.clr_sticky) begin
            cnt_nxt_s = {{(CNT_W-1){1'b0}}, hit_s};
        end else if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign bus.illegal_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_ff_bank.sv
// Directed, table-driven bench for ff_bank (WIDTH=8, CNT_W=2).
module tb_ff_bank;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] q;
        logic [7:0] qb;
        logic       ill;
        logic       st;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        bus.en         = v.en;
        bus.mode       = v.mode;
        bus.a          = v.a;
        bus.b          = v.b;
        bus.clr_sticky = v.clr;
        @(posedge clk);
        #1;
        check("q", idx, bus.q, v.q);
        check("q_bar", idx, bus.q_bar, v.qb);
        check("illegal", idx, {7'd0, bus.illegal}, {7'd0, v.ill});
        check("illegal_sticky", idx, {7'd0, bus.illegal_sticky}, {7'd0, v.st});
`ifdef FF_BANK_ILLEGAL_CNT_EN
        check("illegal_cnt", idx, {6'd0, bus.illegal_cnt}, {6'd0, v.cnt});
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [7:0] q, input logic [7:0] qb,
                                input logic il, input logic st, input logic [1:0] cn);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.a = a; v.b = b; v.clr = c;
        v.q = q; v.qb = qb; v.ill = il; v.st = st; v.cnt = cn;
        return v;
    endfunction

    initial begin
        rst = 1'b0; bus.en = 1'b0; bus.mode = 2'b00;
        bus.a = 8'h00; bus.b = 8'h00; bus.clr_sticky = 1'b0;

        //            rst   en    mode   a      b      clr   q      qb     ill   st    cnt
        vecs[0]  = mk(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 2'd0);
        vecs[1]  = mk(1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 2'd0);
        vecs[2]  = mk(1'b0, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 2'd0);
        vecs[3]  = mk(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 2'd0);
        // SR truth table on channels 0..3: 00, 01, 10, 11
        vecs[4]  = mk(1'b0, 1'b1, 2'b10, 8'h0C, 8'h0A, 1'b0, 8'h04, 8'hF3, 1'b1, 1'b1, 2'd1);
        vecs[5]  = mk(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'h04, 8'hF3, 1'b0, 1'b1, 2'd1);
        // T recovers channel 3 from 0/0
        vecs[6]  = mk(1'b0, 1'b1, 2'b01, 8'h08, 8'h00, 1'b0, 8'h0C, 8'hF3, 1'b0, 1'b1, 2'd1);
        vecs[7]  = mk(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'hF3, 8'h0C, 1'b0, 1'b1, 2'd1);
        vecs[8]  = mk(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'h0C, 8'hF3, 1'b0, 1'b1, 2'd1);
        // clear without hit
        vecs[9]  = mk(1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1, 8'h0C, 8'hF3, 1'b0, 1'b0, 2'd0);
        // five illegal edges: saturation 1,2,3,3,3
        vecs[10] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd1);
        vecs[11] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd2);
        vecs[12] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd3);
        vecs[13] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd3);
        vecs[14] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b0, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd3);
        // clear colliding with a hit
        vecs[15] = mk(1'b0, 1'b1, 2'b10, 8'h01, 8'h01, 1'b1, 8'h0C, 8'hF2, 1'b1, 1'b1, 2'd1);
        // en=0 masks forbidden inputs and drops illegal
        vecs[16] = mk(1'b0, 1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'h0C, 8'hF2, 1'b0, 1'b1, 2'd1);
        vecs[17] = mk(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'hA5, 1'b0, 1'b0, 2'd0);
        // SR 0/0 on channel 7 only, hold others
        vecs[18] = mk(1'b0, 1'b1, 2'b10, 8'h80, 8'h80, 1'b0, 8'h5A, 8'h25, 1'b1, 1'b1, 2'd1);

        for (int i = 0; i < 19; i++) apply(i, vecs[i]);

        // reset mid-operation while JK toggling with count at 2
        apply(100, mk(1'b0, 1'b1, 2'b10, 8'h80, 8'h80, 1'b0, 8'h5A, 8'h25, 1'b1, 1'b1, 2'd2));
        apply(101, mk(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b1, 2'd2));
        apply(102, mk(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 2'd0));
        apply(103, mk(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 2'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
